// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
//
// Shared definitions for the memory-stage access controller:
//   - trunk_mode codes describing access size and load extension
//   - FSM state encoding for mem_access_unit
//   - small helpers that decode the access size and build byte enables
//     and lane-replicated store data
// ---------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [2:0] TM_WORD   = 3'b000;
    localparam logic [2:0] TM_HALF_U = 3'b001;
    localparam logic [2:0] TM_HALF_S = 3'b010;
    localparam logic [2:0] TM_BYTE_U = 3'b011;
    localparam logic [2:0] TM_BYTE_S = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Codes 101-111 are not defined as sub-word accesses, so they fall
    // through to a full word access.
    function automatic size_t decode_size(input logic [2:0] tm);
        size_t sz;
        case (tm)
            TM_HALF_U, TM_HALF_S: sz = SZ_HALF;
            TM_BYTE_U, TM_BYTE_S: sz = SZ_BYTE;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_signed_mode(input logic [2:0] tm);
        return (tm == TM_HALF_S) || (tm == TM_BYTE_S);
    endfunction

    // Bytes can never be misaligned; halves need an even address and
    // words need both low address bits clear.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // The memory picks the lane from the byte enables, so the store value
    // is simply copied into every lane it could land in.
    function automatic logic [31:0] replicate_store(input size_t sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
//
// Combinational lane select and zero/sign extension of a data-memory read
// word.
//
// Ports:
//   rdata      in  32  raw word returned by the data memory
//   addr       in   2  byte offset of the access inside the word
//   trunk_mode in   3  access size/sign code (mem_access_pkg TM_*)
//   data_out   out 32  extracted and extended load value
// ---------------------------------------------------------------------------
module load_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  trunk_mode,
    output logic [31:0] data_out
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase

        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        sign_ext  = is_signed_mode(trunk_mode);

        case (decode_size(trunk_mode))
            SZ_BYTE: data_out = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: data_out = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access controller sitting after the EX/MEM register. It
// launches one request/ready transaction per memory op, aligns and extends
// load data for MEM/WB, and stalls the upstream pipeline while the access
// is in flight. A DONE bubble after every op keeps the same EX/MEM contents
// from being launched twice before the register advances.
//
// Optional feature (macro MEM_ACCESS_TIMEOUT_EN): a watchdog abandons an
// access after TIMEOUT_CYCLES ACCESS cycles without dmem_ready and pulses
// timeout_err_out. Without the macro the access waits indefinitely and
// timeout_err_out is tied to 0.
//
// Ports:
//   clock, reset          clock and async active-high reset
//   MemRead_in/MemWrite_in   memory op controls from EX/MEM
//   trunk_mode_in         access size/sign code
//   addr_in               byte address
//   store_data_in         store value
//   dmem_req/we/addr/be/wdata   registered data-memory request
//   dmem_rdata, dmem_ready      data-memory response
//   load_data_out         registered load value, held until next load
//   load_valid            one-cycle pulse on load completion
//   stall                 combinational upstream freeze
//   misalign_out          one-cycle pulse for a misaligned op
//   timeout_err_out       one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [2:0]        trunk_mode_in,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       store_data_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic [31:0]       load_data_out,
    output logic              load_valid,
    output logic              stall,
    output logic              misalign_out,
    output logic              timeout_err_out
);

    state_t            state_q,      state_d;
    logic              req_q,        req_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [3:0]        be_q,         be_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic              rd_q,         rd_d;
    logic [2:0]        mode_q,       mode_d;
    logic [1:0]        lane_q,       lane_d;
    logic [31:0]       load_data_q,  load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              misalign_q,   misalign_d;

    logic              op;
    size_t             size_in;
    logic [31:0]       extracted;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              timeout_q,    timeout_d;
`else
    logic [31:0]       unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // Word-address bits above the memory's range are intentionally dropped.
    generate
        if (ADDR_W < 30) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^addr_in[31:ADDR_W+2];
        end
    endgenerate

    assign op      = MemRead_in | MemWrite_in;
    assign size_in = decode_size(trunk_mode_in);

    // Lane and mode are captured at launch so extraction does not depend on
    // the EX/MEM register still holding the op when ready arrives.
    load_extract u_load_extract (
        .rdata      (dmem_rdata),
        .addr       (lane_q),
        .trunk_mode (mode_q),
        .data_out   (extracted)
    );

    // Next-state and registered-output logic. Pulse outputs default low;
    // everything else holds unless the current state updates it.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        mode_d       = mode_q;
        lane_d       = lane_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (is_misaligned(size_in, addr_in[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_ACCESS;
                        req_d   = 1'b1;
                        we_d    = MemWrite_in;
                        addr_d  = addr_in[ADDR_W+1:2];
                        be_d    = byte_enables(size_in, addr_in[1:0]);
                        wdata_d = replicate_store(size_in, store_data_in);
                        // A write wins when both controls are set.
                        rd_d    = MemRead_in & ~MemWrite_in;
                        mode_d  = trunk_mode_in;
                        lane_d  = addr_in[1:0];
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end

            ST_ACCESS: begin
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (rd_q) begin
                        load_data_d  = extracted;
                        load_valid_d = 1'b1;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (int'(cnt_q) + 1 >= TIMEOUT_CYCLES) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                    if (rd_q) begin
                        load_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            mode_q       <= '0;
            lane_q       <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            mode_q       <= mode_d;
            lane_q       <= lane_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Watchdog counter and its error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err_out = timeout_q;
`else
    assign timeout_err_out = 1'b0;
`endif

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign load_data_out = load_data_q;
    assign load_valid    = load_valid_q;
    assign misalign_out  = misalign_q;

    // Stall covers the launch cycle and the whole access, but not DONE.
    assign stall = ((state_q == ST_IDLE) & op) | (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit: a table of directed ops with
// hand-computed results, hand-written sequences for reset during an access
// and back-to-back ops, and random ops checked against a transaction-level
// model of access size, alignment, lane replication and load extension.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int TB_ADDR_W = 11;
`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif
    localparam int NEVER = 1000;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expLoad;
        logic        expMis;
    } opVec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              MemRead_in = 1'b0;
    logic              MemWrite_in = 1'b0;
    logic [2:0]        trunk_mode_in = '0;
    logic [31:0]       addr_in = '0;
    logic [31:0]       store_data_in = '0;
    logic              dmem_req;
    logic              dmem_we;
    logic [TB_ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata = '0;
    logic              dmem_ready = 1'b0;
    logic [31:0]       load_data_out;
    logic              load_valid;
    logic              stall;
    logic              misalign_out;
    logic              timeout_err_out;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expLoadHeld = '0;

    mem_access_unit #(
        .ADDR_W         (TB_ADDR_W),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .MemRead_in      (MemRead_in),
        .MemWrite_in     (MemWrite_in),
        .trunk_mode_in   (trunk_mode_in),
        .addr_in         (addr_in),
        .store_data_in   (store_data_in),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .load_data_out   (load_data_out),
        .load_valid      (load_valid),
        .stall           (stall),
        .misalign_out    (misalign_out),
        .timeout_err_out (timeout_err_out)
    );

    always #5 clock = ~clock;

    // Reference model: sizes in bytes, alignment by modulo, replication and
    // extension by plain arithmetic.
    function automatic int modelSize(input logic [2:0] mode);
        if (mode == 3'd1 || mode == 3'd2) return 2;
        if (mode == 3'd3 || mode == 3'd4) return 1;
        return 4;
    endfunction

    function automatic opVec_t modelFill(input opVec_t v);
        opVec_t      r = v;
        int          size = modelSize(v.mode);
        int          off  = int'(v.addr % 4);
        longint      mask = (64'd1 << (8 * size)) - 1;
        longint      val;
        logic [31:0] beWide;
        r.expMis = (v.rd || v.wr) && ((off % size) != 0);
        beWide   = ((32'd1 << size) - 1) << off;
        r.expBe  = beWide[3:0];
        if (size == 1)      r.expWdata = (v.data & 32'hFF) * 32'h01010101;
        else if (size == 2) r.expWdata = (v.data & 32'hFFFF) * 32'h00010001;
        else                r.expWdata = v.data;
        val = (longint'({32'd0, v.rdata}) >> (8 * off)) & mask;
        if ((v.mode == 3'd2 || v.mode == 3'd4) && val >= (64'd1 << (8 * size - 1)))
            val = val - (mask + 1);
        r.expLoad = 32'(val);
        return r;
    endfunction

    function automatic opVec_t mkVec(input logic rd, input logic wr, input logic [2:0] mode,
                                     input logic [31:0] addr, input logic [31:0] data,
                                     input logic [31:0] rdata, input int delay,
                                     input logic [3:0] be, input logic [31:0] wdata,
                                     input logic [31:0] ld, input logic mis);
        opVec_t v;
        v.rd = rd; v.wr = wr; v.mode = mode; v.addr = addr; v.data = data;
        v.rdata = rdata; v.delay = delay; v.expBe = be; v.expWdata = wdata;
        v.expLoad = ld; v.expMis = mis;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Drives one op, plays the memory with the vector's ready delay, and
    // compares what the DUT did across the whole transaction.
    task automatic applyStimulus(input opVec_t v, input string name);
        int          stallCnt = 0, reqCnt = 0, lvCnt = 0, misCnt = 0, tmoCnt = 0, unstable = 0;
        logic        capWe = 1'b0;
        logic [3:0]  capBe = '0;
        logic [31:0] capAddr = '0, capWdata = '0;
        logic        done = 1'b0;
        logic        hasReq = (v.rd || v.wr) && !v.expMis;
        logic        isLoad = hasReq && v.rd && !v.wr;
        int          expReq, expStall;

        @(negedge clock);
        MemRead_in = v.rd; MemWrite_in = v.wr; trunk_mode_in = v.mode;
        addr_in = v.addr; store_data_in = v.data;
        dmem_ready = 1'b0; dmem_rdata = $urandom;
        #1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (stall) stallCnt++;
            if (load_valid) lvCnt++;
            if (misalign_out) misCnt++;
            if (timeout_err_out) tmoCnt++;
            if (dmem_req) begin
                if (reqCnt == 0) begin
                    capWe = dmem_we; capBe = dmem_be;
                    capAddr = 32'(dmem_addr); capWdata = dmem_wdata;
                end else if (capWe !== dmem_we || capBe !== dmem_be ||
                             capAddr !== 32'(dmem_addr) || capWdata !== dmem_wdata) begin
                    unstable++;
                end
                reqCnt++;
                if (v.delay != NEVER && reqCnt > v.delay) begin
                    dmem_ready = 1'b1; dmem_rdata = v.rdata;
                end else begin
                    dmem_ready = 1'b0; dmem_rdata = $urandom;
                end
            end else begin
                dmem_ready = 1'b0; dmem_rdata = $urandom;
            end
            if (!stall) done = 1'b1;
            else begin
                @(negedge clock);
                #1;
            end
        end
        MemRead_in = 1'b0; MemWrite_in = 1'b0; dmem_ready = 1'b0;
        @(negedge clock);
        #1;

        if (isLoad) expLoadHeld = (v.delay == NEVER) ? 32'd0 : v.expLoad;
        expReq   = !hasReq ? 0 : (v.delay == NEVER ? TB_TMO : v.delay + 1);
        expStall = !(v.rd || v.wr) ? 0 : (v.expMis ? 1 : expReq + 1);

        checkOutput({name, ".bound"}, 32'(done), 32'd1);
        checkOutput({name, ".stallCycles"}, 32'(stallCnt), 32'(expStall));
        checkOutput({name, ".reqCycles"}, 32'(reqCnt), 32'(expReq));
        checkOutput({name, ".misalign"}, 32'(misCnt), 32'(v.expMis));
        checkOutput({name, ".loadValid"}, 32'(lvCnt), 32'(isLoad && v.delay != NEVER));
        checkOutput({name, ".timeout"}, 32'(tmoCnt), 32'(hasReq && v.delay == NEVER));
        checkOutput({name, ".loadData"}, load_data_out, expLoadHeld);
        checkOutput({name, ".idleReq"}, 32'(dmem_req), 32'd0);
        if (hasReq) begin
            checkOutput({name, ".we"}, 32'(capWe), 32'(v.wr));
            checkOutput({name, ".be"}, 32'(capBe), 32'(v.expBe));
            checkOutput({name, ".addr"}, capAddr, (v.addr >> 2) & ((32'd1 << TB_ADDR_W) - 1));
            checkOutput({name, ".wdata"}, capWdata, v.expWdata);
            checkOutput({name, ".stable"}, 32'(unstable), 32'd0);
        end
    endtask

    initial begin
        opVec_t vecs[$];
        opVec_t rv;
        int     b2bStall[6] = '{1, 1, 0, 1, 1, 0};
        int     b2bValid[6] = '{0, 0, 1, 0, 0, 1};

        // Directed vectors with hand-computed results.
        vecs.push_back(mkVec(1, 0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mkVec(1, 0, 3'b100, 32'h13, 32'h0, 32'h80112233, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mkVec(1, 0, 3'b011, 32'h13, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 32'h00000080, 0));
        vecs.push_back(mkVec(0, 1, 3'b001, 32'h6, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'hABCDABCD, 32'h0, 0));
        vecs.push_back(mkVec(1, 0, 3'b000, 32'h2, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0, 1));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h2, 32'h0, 32'h80011234, 2, 4'b1100, 32'h0, 32'hFFFF8001, 0));
        vecs.push_back(mkVec(0, 1, 3'b011, 32'h1, 32'h123456AB, 32'h0, 0, 4'b0010, 32'hABABABAB, 32'h0, 0));
        vecs.push_back(mkVec(1, 1, 3'b000, 32'h8, 32'h11223344, 32'h55555555, 1, 4'b1111, 32'h11223344, 32'h0, 0));
        vecs.push_back(mkVec(1, 0, 3'b001, 32'h5, 32'h0, 32'h0, 0, 4'b0011, 32'h0, 32'h0, 1));
        vecs.push_back(mkVec(1, 0, 3'b111, 32'hC, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mkVec(1, 0, 3'b011, 32'h1, 32'h0, 32'h12348000, 0, 4'b0010, 32'h0, 32'h00000080, 0));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h4, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0, 0));
`ifdef MEM_ACCESS_TIMEOUT_EN
        vecs.push_back(mkVec(1, 0, 3'b000, 32'h20, 32'h0, 32'h0, NEVER, 4'b1111, 32'h0, 32'h0, 0));
`endif

        // Reset values.
        #2;
        checkOutput("reset.req", 32'(dmem_req), 32'd0);
        checkOutput("reset.loadData", load_data_out, 32'd0);
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.timeout", 32'(timeout_err_out), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during ACCESS abandons the load.
        @(negedge clock);
        MemRead_in = 1'b1; trunk_mode_in = 3'b000; addr_in = 32'h40; store_data_in = 32'h9;
        dmem_ready = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("midReset.reqBefore", 32'(dmem_req), 32'd1);
        MemRead_in = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midReset.req", 32'(dmem_req), 32'd0);
        checkOutput("midReset.outs", {dmem_be, 3'b0, dmem_we, 8'b0, 5'b0, dmem_addr}, 32'd0);
        checkOutput("midReset.wdata", dmem_wdata, 32'd0);
        checkOutput("midReset.loadData", load_data_out, 32'd0);
        checkOutput("midReset.pulses", {29'd0, load_valid, misalign_out, stall}, 32'd0);
        expLoadHeld = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(vecs[0], "afterReset");

        // Back-to-back loads with the op held: one DONE bubble between them,
        // and ready held high outside ACCESS has no effect.
        @(negedge clock);
        MemRead_in = 1'b1; MemWrite_in = 1'b0; trunk_mode_in = 3'b000;
        addr_in = 32'h24; dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
        #1;
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("b2b.stall%0d", i), 32'(stall), 32'(b2bStall[i]));
            checkOutput($sformatf("b2b.valid%0d", i), 32'(load_valid), 32'(b2bValid[i]));
            if (i < 5) begin
                @(negedge clock);
                #1;
            end
        end
        checkOutput("b2b.loadData", load_data_out, 32'h0BADF00D);
        expLoadHeld = 32'h0BADF00D;
        MemRead_in = 1'b0; dmem_ready = 1'b0;
        @(negedge clock);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            rv.rd    = 1'($urandom_range(0, 1));
            rv.wr    = 1'($urandom_range(0, 1));
            rv.mode  = 3'($urandom_range(0, 7));
            rv.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
            rv.data  = $urandom;
            rv.rdata = $urandom;
            rv.delay = $urandom_range(0, 3);
            rv = modelFill(rv);
            applyStimulus(rv, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller on the consumer side of the EX/MEM pipeline register. It turns the registered ALU result (address), second-register value (store data), MemRead/MemWrite and trunk_mode into a request/ready transaction on the data-memory port. It aligns and extends load data and raises a pipeline stall while an access is in flight. Load results feed the MEM/WB register.

## Interface
- ADDR_W, 11, data-memory word-address width; dmem_addr = addr_in[ADDR_W+1:2]
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the macro in Configuration
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state and registered outputs immediately
- MemRead_in / MemWrite_in  in  1 each  from EX/MEM control outputs
- trunk_mode_in  in  3  access size/sign: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 treated as word
- addr_in  in  32  byte address (EX/MEM result)
- store_data_in  in  32  EX/MEM registro_2 value
- dmem_req  out  1  registered request, held until dmem_ready
- dmem_we  out  1  registered; 1 = write
- dmem_addr  out  ADDR_W  registered word address
- dmem_be  out  4  registered byte enables
- dmem_wdata  out  32  registered, lane-replicated store data
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- dmem_ready  in  1  completes the current request
- load_data_out  out  32  registered, extracted load value; holds until next load
- load_valid  out  1  one-cycle pulse on load completion
- stall  out  1  combinational; freezes upstream pipeline registers
- misalign_out  out  1  one-cycle pulse for a misaligned op
- timeout_err_out  out  1  one-cycle pulse; tied 0 without the macro

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE. All registered outputs reset to 0.
- IDLE, op = MemRead_in|MemWrite_in:
  - Aligned: go to ACCESS; register dmem_req=1, dmem_we=MemWrite_in, dmem_addr, dmem_be, dmem_wdata.
  - Misaligned (half with addr_in[0]=1, word with addr_in[1:0]≠0): no request; pulse misalign_out; go to DONE.
- Both MemRead_in and MemWrite_in set: write performed, read ignored, no load_valid.
- Byte enables:
  - byte: 0001<<addr_in[1:0]
  - half: 0011<<addr_in[1:0]
  - word: 1111
- Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- ACCESS: hold all dmem_* outputs stable. When dmem_ready=1:
  - Drop dmem_req and go to DONE.
  - For a read, load_data_out = selected lane of dmem_rdata, zero- or sign-extended per trunk_mode; pulse load_valid.
- DONE: one cycle, then IDLE unconditionally. Prevents relaunching the same EX/MEM contents before the register advances.
- stall = (IDLE & op) | ACCESS. It is 0 in DONE and whenever no op is present.

## Timing
- Minimum latency is 2 rising edges from op visible to completion:
  - Edge 1: IDLE→ACCESS, dmem_req rises.
  - Edge 2: dmem_ready=1 sampled, load_valid=1, DONE.
- Each cycle dmem_ready stays low adds one cycle. dmem_ready outside ACCESS is ignored.
- Misaligned op: edge 1 pulses misalign_out and enters DONE.
- Reset asserted mid-ACCESS: dmem_req drops asynchronously and the FSM goes to IDLE. The partial access is abandoned with no load_valid.
- Back-to-back ops: one DONE bubble between them.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - An 8-bit-minimum counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If the count reaches TIMEOUT_CYCLES with dmem_ready still 0: drop dmem_req, pulse timeout_err_out, go to DONE. load_data_out is set to 0 for reads, and load_valid is not pulsed.
- Undefined: no counter; ACCESS waits indefinitely; timeout_err_out constant 0.

## Structure
- Package mem_access_pkg holds:
  - trunk_mode codes (TM_WORD, TM_HALF_U, TM_HALF_S, TM_BYTE_U, TM_BYTE_S)
  - FSM state encoding
- Sub-module load_extract: combinational lane select and zero/sign extension, inputs rdata, addr[1:0], trunk_mode.

## Test plan
- Word load, addr 0x10, rdata 0xDEADBEEF with ready on first ACCESS cycle -> dmem_addr=4, be=1111, load_data_out=0xDEADBEEF, load_valid at edge 2, stall high for 2 cycles.
- Signed byte load at addr 0x13, rdata 0x80112233 -> be=1000, load_data_out=0xFFFFFF80. Same with trunk 011 -> 0x00000080.
- Half store at addr 0x6, data 0x0000ABCD, ready delayed 3 cycles -> we=1, be=1100, wdata=0xABCDABCD held stable, stall high for 5 cycles, no load_valid.
- Word load at addr 0x2 -> no dmem_req, misalign_out pulse, DONE, stall high 1 cycle.
- Reset asserted during ACCESS -> dmem_req=0 immediately, state IDLE, all outputs 0.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> timeout_err_out pulse after 4 ACCESS cycles, dmem_req drops, FSM returns to IDLE via DONE.
